// File: rtl/rvfi_retire_buffer_if.sv
// Retirement record ingress (RVFI probe) and drained-record egress handshake.
// The slave modport is the retire buffer; master is the producer/consumer side.
interface rvfi_retire_buffer_if;
  logic        rvfi_valid_i;
  logic [63:0] rvfi_order_i;
  logic [31:0] rvfi_insn_i;
  logic        rvfi_trap_i;
  logic        rvfi_halt_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_order_o;
  logic [31:0] out_insn_o;
  logic        out_trap_o;
  logic [31:0] out_pc_o;
  logic [4:0]  out_rd_addr_o;
  logic [31:0] out_rd_wdata_o;

  modport slave (
    input  rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_halt_i,
           rvfi_pc_rdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, out_ready_i,
    output out_valid_o, out_order_o, out_insn_o, out_trap_o, out_pc_o,
           out_rd_addr_o, out_rd_wdata_o
  );

  modport master (
    output rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_halt_i,
           rvfi_pc_rdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, out_ready_i,
    input  out_valid_o, out_order_o, out_insn_o, out_trap_o, out_pc_o,
           out_rd_addr_o, out_rd_wdata_o
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// FIFO capturing RVFI retirement records and draining them over valid/ready.
// Optional order-sequence checker enabled by defining RVFI_RETIRE_ORDER_CHECK_EN.
module rvfi_retire_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  rvfi_retire_buffer_if.slave        rvfi,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic                       halted_o,
  output logic                       order_err_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  in_rec, head;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  halted_q, halted_d, overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  out_valid, full, pop, push, drop, accept;

  assign in_rec = '{order:    rvfi.rvfi_order_i,
                    insn:     rvfi.rvfi_insn_i,
                    trap:     rvfi.rvfi_trap_i,
                    pc:       rvfi.rvfi_pc_rdata_i,
                    rd_addr:  rvfi.rvfi_rd_addr_i,
                    rd_wdata: rvfi.rvfi_rd_wdata_i};

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = out_valid && rvfi.out_ready_i;
  assign accept    = rvfi.rvfi_valid_i && !halted_q;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      halted_d   = 1'b0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (rvfi.rvfi_halt_i) halted_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; outputs are gated by out_valid so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= in_rec;
  end

  assign head                = mem_q[rd_ptr_q];
  assign rvfi.out_valid_o    = out_valid;
  assign rvfi.out_order_o    = out_valid ? head.order   : '0;
  assign rvfi.out_insn_o     = out_valid ? head.insn    : '0;
  assign rvfi.out_trap_o     = out_valid ? head.trap    : 1'b0;
  assign rvfi.out_pc_o       = out_valid ? head.pc      : '0;
  assign rvfi.out_rd_addr_o  = out_valid ? head.rd_addr : '0;
  assign rvfi.out_rd_wdata_o = (out_valid && head.rd_addr != '0) ? head.rd_wdata : '0;

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign halted_o   = halted_q;

`ifdef RVFI_RETIRE_ORDER_CHECK_EN
  logic [63:0] exp_q, exp_d;
  logic        seen_q, seen_d, oerr_q, oerr_d;

  // Only accepted pushes advance the expectation, so a drop shows up as a gap.
  always_comb begin
    exp_d  = exp_q;
    seen_d = seen_q;
    oerr_d = oerr_q;
    if (clear_i) begin
      exp_d  = '0;
      seen_d = 1'b0;
      oerr_d = 1'b0;
    end else if (push) begin
      if (seen_q && rvfi.rvfi_order_i != exp_q) oerr_d = 1'b1;
      seen_d = 1'b1;
      exp_d  = rvfi.rvfi_order_i + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q  <= '0;
      seen_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      seen_q <= seen_d;
      oerr_q <= oerr_d;
    end
  end

  assign order_err_o = oerr_q;
`else
  assign order_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Randomized scoreboard bench for rvfi_retire_buffer with a queue-based reference model.
module tb_rvfi_retire_buffer;
  localparam int DEPTH = 8;
  localparam int DW    = 16;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [3:0]    count;
  logic          overflow, halted, order_err;
  logic [DW-1:0] drop_cnt;

  rvfi_retire_buffer_if intf ();

  rvfi_retire_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .rvfi(intf.slave),
    .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt),
    .halted_o(halted), .order_err_o(order_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model state
  exp_t        sb[$];
  int          m_cnt = 0, m_drop = 0;
  bit          m_halt = 0, m_ovf = 0, m_seen = 0, m_oerr = 0;
  logic [63:0] m_exp = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0; m_drop = 0; m_halt = 0; m_ovf = 0; m_seen = 0; m_oerr = 0; m_exp = '0;
  endtask

  // Model: evaluates the capture rules at each active edge from the applied inputs.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || clear) model_reset();
    else begin
      bit pop, acc;
      exp_t e;
      pop = (m_cnt != 0) && intf.out_ready_i;
      acc = intf.rvfi_valid_i && !m_halt;
      if (acc && (m_cnt < DEPTH || pop)) begin
        e.order = intf.rvfi_order_i; e.insn = intf.rvfi_insn_i; e.trap = intf.rvfi_trap_i;
        e.pc = intf.rvfi_pc_rdata_i; e.rd = intf.rvfi_rd_addr_i;
        e.wdata = (intf.rvfi_rd_addr_i == 0) ? 32'd0 : intf.rvfi_rd_wdata_i;
        sb.push_back(e);
        m_cnt++;
`ifdef RVFI_RETIRE_ORDER_CHECK_EN
        if (m_seen && intf.rvfi_order_i != m_exp) m_oerr = 1;
        m_seen = 1;
        m_exp  = intf.rvfi_order_i + 1;
`endif
        if (intf.rvfi_halt_i) m_halt = 1;
      end else if (acc) begin
        m_ovf = 1;
        if (m_drop != (1 << DW) - 1) m_drop++;
      end
      if (pop) m_cnt--;
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  initial forever begin
    @(negedge clk);
    chk("count", 64'(count), 64'(m_cnt));
    chk("out_valid", 64'(intf.out_valid_o), 64'(m_cnt != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("order_err", 64'(order_err), 64'(m_oerr));
    if (intf.out_valid_o && intf.out_ready_i) begin
      if (sb.size() == 0) chk("pop_on_empty_model", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_order", intf.out_order_o, e.order);
        chk("out_insn", 64'(intf.out_insn_o), 64'(e.insn));
        chk("out_trap", 64'(intf.out_trap_o), 64'(e.trap));
        chk("out_pc", 64'(intf.out_pc_o), 64'(e.pc));
        chk("out_rd_addr", 64'(intf.out_rd_addr_o), 64'(e.rd));
        chk("out_rd_wdata", 64'(intf.out_rd_wdata_o), 64'(e.wdata));
      end
    end
  end

  task automatic drive(bit v, logic [63:0] ord, bit hlt, bit rdy,
                       logic [31:0] pc, logic [4:0] rd, logic [31:0] wd);
    intf.rvfi_valid_i    = v;
    intf.rvfi_order_i    = ord;
    intf.rvfi_insn_i     = $urandom;
    intf.rvfi_trap_i     = 1'($urandom_range(0, 1));
    intf.rvfi_halt_i     = hlt;
    intf.rvfi_pc_rdata_i = pc;
    intf.rvfi_rd_addr_i  = rd;
    intf.rvfi_rd_wdata_i = wd;
    intf.out_ready_i     = rdy;
    @(posedge clk); #1;
  endtask

  task automatic push(logic [63:0] ord, bit hlt, bit rdy);
    drive(1'b1, ord, hlt, rdy, 32'h1000 + 32'(ord) * 4, 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic idle(bit rdy, int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, rdy, '0, '0, '0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1'b0, 1);
    clear = 1'b0;
  endtask

  initial begin
    logic [63:0] ord;
    bit exp_oerr;
`ifdef RVFI_RETIRE_ORDER_CHECK_EN
    exp_oerr = 1;
`else
    exp_oerr = 0;
`endif
    idle(1'b0, 2);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(intf.out_valid_o), 64'd0);
    rst_n = 1'b1;
    idle(1'b0, 1);

    // Single record, 1-cycle latency
    drive(1'b1, 64'd5, 1'b0, 1'b1, 32'h8000_0000, 5'd3, 32'hDEAD_BEEF);
    chk("single_valid", 64'(intf.out_valid_o), 64'd1);
    chk("single_order", intf.out_order_o, 64'd5);
    chk("single_pc", 64'(intf.out_pc_o), 64'h8000_0000);
    chk("single_wdata", 64'(intf.out_rd_wdata_o), 64'hDEAD_BEEF);
    idle(1'b1, 1);
    chk("single_count_after", 64'(count), 64'd0);

    // Fill and overflow
    do_clear();
    for (int i = 0; i < 10; i++) push(64'(i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drops", 64'(drop_cnt), 64'd2);
    chk("fill_head", intf.out_order_o, 64'd0);
    idle(1'b1, 10);
    chk("drain_count", 64'(count), 64'd0);

    // Full with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 8; i++) push(64'(i), 1'b0, 1'b0);
    push(64'd8, 1'b0, 1'b1);
    chk("fullpp_count", 64'(count), 64'd8);
    chk("fullpp_drops", 64'(drop_cnt), 64'd0);
    chk("fullpp_head", intf.out_order_o, 64'd1);
    idle(1'b1, 9);

    // Halt
    do_clear();
    push(64'd3, 1'b1, 1'b0);
    push(64'd4, 1'b0, 1'b0);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_count", 64'(count), 64'd1);
    chk("halt_drops", 64'(drop_cnt), 64'd0);
    idle(1'b1, 3);
    chk("halt_drained", 64'(count), 64'd0);

    // rd = x0 forces write data to zero
    do_clear();
    drive(1'b1, 64'd0, 1'b0, 1'b0, 32'h2000, 5'd0, 32'h1234);
    chk("x0_wdata", 64'(intf.out_rd_wdata_o), 64'd0);
    idle(1'b1, 2);

    // Order check
    do_clear();
    push(64'd0, 1'b0, 1'b1);
    push(64'd1, 1'b0, 1'b1);
    push(64'd2, 1'b0, 1'b1);
    push(64'd4, 1'b0, 1'b1);
    chk("order_err_gap", 64'(order_err), 64'(exp_oerr));
    do_clear();
    chk("order_err_clear", 64'(order_err), 64'd0);

    // Randomized traffic with occasional clear, halt, gaps and a mid-burst reset
    ord = 64'd100;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      if (i == 1500) begin
        rst_n = 1'b0;
        idle(1'b0, 2);
        rst_n = 1'b1;
      end
      clear = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 2) != 0);
      if (v) ord = ord + (($urandom_range(0, 29) == 0) ? 64'd2 : 64'd1);
      drive(v, ord, ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
            $urandom, 5'($urandom_range(0, 31)), $urandom);
    end
    clear = 1'b0;
    idle(1'b1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
